// File: rtl/ip_codma_crc_ctrl.sv
// ---------------------------------------------------------------------------
// ip_codma_crc_ctrl
//
// Purpose:
//   Computes a 32-bit CRC (polynomial 0x04C11DB7, non-reflected, MSB-first,
//   init 0xFFFFFFFF) over 1..8 captured 32-bit words, folding one whole word
//   per clock. A job is started from IDLE, runs one cycle per word in RUN,
//   and publishes the result from DONE.
//
// Configuration macro:
//   CODMA_CRC_FINAL_XOR_EN  defined   -> crc_o = ~crc register (CRC-32/BZIP2)
//                           undefined -> crc_o =  crc register (CRC-32/MPEG-2)
//
// Ports:
//   clk_i        in   rising-edge clock
//   reset_n_i    in   asynchronous active-low reset
//   start_i      in   job request, sampled only in IDLE
//   len_i[3:0]   in   number of words, legal 1..8
//   data_reg_i   in   [7:0][31:0] source words, word 0 processed first
//   abort_i      in   cancels a job while in RUN
//   busy_o       out  high in RUN and DONE
//   crc_o[31:0]  out  last completed CRC, held between jobs
//   crc_valid_o  out  one-cycle pulse when crc_o is updated
//   err_o        out  one-cycle pulse on a start with an illegal length
//   state_dbg_o  out  current FSM state (debug visibility)
//
// Handshake: there is no ready signal. start_i is a level request that is
// accepted on any rising edge where the FSM is in IDLE; while busy_o is high
// start_i is ignored and nothing is queued. len_i and data_reg_i only need to
// be valid on the accepting edge, since they are captured there.
// ---------------------------------------------------------------------------
module ip_codma_crc_ctrl (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [3:0]       len_i,
    input  logic [7:0][31:0] data_reg_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic [31:0]      crc_o,
    output logic             crc_valid_o,
    output logic             err_o,
    output logic [1:0]       state_dbg_o
);

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       len_q, len_d;
    logic [7:0][31:0] data_q, data_d;
    logic [31:0]      crc_reg_q, crc_reg_d;
    logic [31:0]      crc_out_q, crc_out_d;
    logic             crc_valid_q, crc_valid_d;
    logic             err_q, err_d;

    logic             len_legal;
    logic             last_word;
    logic [31:0]      crc_final;

    // Folds 32 data bits into the CRC, MSB first, as 32 unrolled shift steps.
    function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                             input logic [31:0] word);
        logic [31:0] c;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ word[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign len_legal = (len_i != 4'd0) && (len_i <= 4'd8);
    // len_q is 1..8 during a job, so len_q-1 fits the 3-bit index range.
    assign last_word = ({1'b0, idx_q} == (len_q - 4'd1));

`ifdef CODMA_CRC_FINAL_XOR_EN
    assign crc_final = ~crc_reg_q;
`else
    assign crc_final = crc_reg_q;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        data_d      = data_q;
        crc_reg_d   = crc_reg_q;
        crc_out_d   = crc_out_q;
        crc_valid_d = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_legal) begin
                        data_d    = data_reg_i;
                        len_d     = len_i;
                        crc_reg_d = CRC_INIT;
                        idx_d     = 3'd0;
                        state_d   = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Abort wins over the last-word transition.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    crc_reg_d = crc_step(crc_reg_q, data_q[idx_q]);
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                crc_out_d   = crc_final;
                crc_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            len_q       <= 4'd0;
            data_q      <= '0;
            crc_reg_q   <= 32'd0;
            crc_out_q   <= 32'd0;
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            data_q      <= data_d;
            crc_reg_q   <= crc_reg_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
            err_q       <= err_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign crc_o       = crc_out_q;
    assign crc_valid_o = crc_valid_q;
    assign err_o       = err_q;
    assign state_dbg_o = state_q;

endmodule
